// File: rtl/ramb4_s2_arb2.sv
// Round-robin arbiter/sequencer for port A of a 2048x2 dual-port block RAM.
// Optional post-reset clear sweep; stalls port-A accesses colliding with port B.
module ramb4_s2_arb2 #(
  parameter bit         CLEAR_ON_RST = 1'b1,
  parameter logic [1:0] CLEAR_VAL    = 2'b00
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req0_i,
  input  logic        req1_i,
  input  logic        we0_i,
  input  logic        we1_i,
  input  logic [10:0] addr0_i,
  input  logic [10:0] addr1_i,
  input  logic [1:0]  di0_i,
  input  logic [1:0]  di1_i,
  output logic        gnt0_o,
  output logic        gnt1_o,
  output logic        vld0_o,
  output logic        vld1_o,
  input  logic        enb_mon_i,
  input  logic        web_mon_i,
  input  logic [10:0] addrb_mon_i,
  output logic        ena_o,
  output logic        wea_o,
  output logic [10:0] addra_o,
  output logic [1:0]  dia_o,
  output logic        rsta_o,
  input  logic [1:0]  doa_i,
  output logic        ready_o,
  output logic        stall_o
);

  typedef enum logic {ST_CLEAR, ST_RUN} state_t;

  state_t      state_q, state_d;
  logic [10:0] cnt_q, cnt_d;
  logic        last_q, last_d;
  logic        first_q;
  logic        vld0_q, vld1_q, ready_q;
  logic [10:0] addra_q;
  logic [1:0]  dia_q;

  logic        active, run, cand_vld, cand_sel, cand_we, collide, issue;
  logic [10:0] cand_addr;
  logic [1:0]  cand_di;

  // DOA is wired straight from the RAM to the clients; only VLD qualifies it.
  logic unused_doa;
  assign unused_doa = ^doa_i;

  assign rsta_o = 1'b0;

  always_comb begin
    // The cycle right after reset is kept quiet: no RAM access, no grant.
    active    = ~rst_i & ~first_q;
    run       = (state_q == ST_RUN);
    cand_sel  = 1'b0;
    cand_vld  = 1'b0;
    cand_we   = 1'b0;
    cand_addr = cnt_q;
    cand_di   = CLEAR_VAL;
    if (!run) begin
      cand_vld = 1'b1;
      cand_we  = 1'b1;
    end else begin
      cand_sel  = (req0_i & req1_i) ? ~last_q : req1_i;
      cand_vld  = req0_i | req1_i;
      cand_we   = cand_sel ? we1_i   : we0_i;
      cand_addr = cand_sel ? addr1_i : addr0_i;
      cand_di   = cand_sel ? di1_i   : di0_i;
    end

    collide = enb_mon_i & (addrb_mon_i == cand_addr) & (web_mon_i | cand_we);
    issue   = active & cand_vld & ~collide;
    stall_o = active & cand_vld & collide;
    gnt0_o  = issue & run & ~cand_sel;
    gnt1_o  = issue & run & cand_sel;

    ena_o   = issue;
    wea_o   = issue & cand_we;
    addra_o = rst_i ? 11'd0 : (issue ? cand_addr : addra_q);
    dia_o   = rst_i ? 2'd0  : (issue ? cand_di   : dia_q);

    vld0_o  = vld0_q & ~rst_i;
    vld1_o  = vld1_q & ~rst_i;
    ready_o = ready_q & ~rst_i;

    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    if (issue && !run) begin
      cnt_d = cnt_q + 11'd1;
      if (cnt_q == 11'h7FF) state_d = ST_RUN;
    end
    if (issue && run) last_d = cand_sel;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= CLEAR_ON_RST ? ST_CLEAR : ST_RUN;
      cnt_q   <= 11'd0;
      last_q  <= 1'b1;
      first_q <= 1'b1;
      vld0_q  <= 1'b0;
      vld1_q  <= 1'b0;
      ready_q <= 1'b0;
      addra_q <= 11'd0;
      dia_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      first_q <= 1'b0;
      vld0_q  <= gnt0_o & ~we0_i;
      vld1_q  <= gnt1_o & ~we1_i;
      ready_q <= (state_d == ST_RUN);
      if (issue) begin
        addra_q <= cand_addr;
        dia_q   <= cand_di;
      end
    end
  end

endmodule

// File: tb/tb_ramb4_s2_arb2.sv
// Bench for ramb4_s2_arb2: directed clear/arbitration/collision/reset steps,
// then randomized traffic against a request-level arbiter and memory model.
module tb_ramb4_s2_arb2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, req1, we0, we1;
  logic [10:0] addr0, addr1, addrb;
  logic [1:0]  di0, di1;
  logic        gnt0, gnt1, vld0, vld1;
  logic        enb, web;
  logic        ena, wea, rsta, ready, stall;
  logic [10:0] addra;
  logic [1:0]  dia, doa;

  int checks = 0;
  int errors = 0;

  logic [1:0] mem [2048];
  logic [1:0] sh  [2048];

  always #5 clk = ~clk;

  ramb4_s2_arb2 #(.CLEAR_ON_RST(1'b1), .CLEAR_VAL(2'b00)) dut (
    .clk_i(clk), .rst_i(rst),
    .req0_i(req0), .req1_i(req1), .we0_i(we0), .we1_i(we1),
    .addr0_i(addr0), .addr1_i(addr1), .di0_i(di0), .di1_i(di1),
    .gnt0_o(gnt0), .gnt1_o(gnt1), .vld0_o(vld0), .vld1_o(vld1),
    .enb_mon_i(enb), .web_mon_i(web), .addrb_mon_i(addrb),
    .ena_o(ena), .wea_o(wea), .addra_o(addra), .dia_o(dia), .rsta_o(rsta),
    .doa_i(doa), .ready_o(ready), .stall_o(stall)
  );

  // RAM port A model (write-first)
  always @(posedge clk) begin
    if (ena) begin
      if (wea) begin
        mem[addra] <= dia;
        doa        <= dia;
      end else begin
        doa <= mem[addra];
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts in the first cycle after reset; returns the cycle index where READY is seen.
  task automatic run_clear(input int stall_at, input int n_stall,
                           output int ready_cyc, output int writes, output int bad);
    int exp_cnt;
    int left;
    exp_cnt   = 0;
    left      = n_stall;
    ready_cyc = -1;
    writes    = 0;
    bad       = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc > 0 && exp_cnt == stall_at && left > 0) begin
        enb = 1'b1; web = 1'b0; addrb = 11'(stall_at);
      end else begin
        enb = 1'b0;
      end
      @(negedge clk);
      if (ready === 1'b1) begin
        ready_cyc = cyc;
        break;
      end
      if (enb) begin
        check("clear_stall", stall, 1);
        check("clear_stall_ena", ena, 0);
        left--;
      end else if (ena === 1'b1) begin
        if (wea !== 1'b1 || addra !== 11'(exp_cnt) || dia !== 2'b00) bad++;
        exp_cnt++;
        writes++;
      end
      @(posedge clk);
      #1;
    end
    enb = 1'b0;
    if (ready_cyc >= 0) tick();
  endtask

  initial begin
    int rc, wr, bad, nz;
    bit pend[2];
    bit pwe[2];
    logic [10:0] padr[2];
    logic [1:0]  pdi[2];
    int  last_m, c;
    bit  coll, g;
    bit  expv[2];
    logic [1:0] expd[2];
    bit  nv[2];
    logic [1:0] nd[2];

    rst = 1'b1; req0 = 1'b1; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    addr0 = 11'h3; addr1 = 11'h0; di0 = 2'b0; di1 = 2'b0;
    enb = 1'b0; web = 1'b0; addrb = 11'h0;

    // Reset outputs
    tick();
    @(negedge clk);
    check("rst_ena", ena, 0);
    check("rst_wea", wea, 0);
    check("rst_addra", addra, 0);
    check("rst_dia", dia, 0);
    check("rst_rsta", rsta, 0);
    check("rst_gnt0", gnt0, 0);
    check("rst_gnt1", gnt1, 0);
    check("rst_vld", {vld0, vld1}, 0);
    check("rst_ready", ready, 0);
    check("rst_stall", stall, 0);
    tick();
    rst = 1'b0;
    #2;
    check("first_ena", ena, 0);
    check("first_gnt0", gnt0, 0);
    check("first_ready", ready, 0);
    req0 = 1'b0;

    // Clear sweep with no port-B activity
    run_clear(-1, 0, rc, wr, bad);
    check("clear_ready_cycle", rc, 2049);
    check("clear_writes", wr, 2048);
    check("clear_bad_writes", bad, 0);
    nz = 0;
    for (int i = 0; i < 2048; i++) if (mem[i] !== 2'b00) nz++;
    check("clear_readback", nz, 0);

    // Write then read
    req0 = 1'b1; we0 = 1'b1; addr0 = 11'h155; di0 = 2'b10;
    @(negedge clk);
    check("wr_gnt0", gnt0, 1);
    check("wr_ena_wea", {ena, wea}, 2'b11);
    check("wr_addra", addra, 11'h155);
    check("wr_dia", dia, 2'b10);
    tick();
    req0 = 1'b0; req1 = 1'b1; we1 = 1'b0; addr1 = 11'h155;
    @(negedge clk);
    check("rd_gnt1", gnt1, 1);
    check("rd_wea", {ena, wea}, 2'b10);
    tick();
    req1 = 1'b1; we1 = 1'b1; addr1 = 11'h020; di1 = 2'b01;
    @(negedge clk);
    check("rd_vld1", vld1, 1);
    check("rd_doa", doa, 2'b10);
    check("wr1_gnt1", gnt1, 1);
    tick();

    // Tie-break: both reading, R1 was last -> R0, R1, R0, R1
    req0 = 1'b1; we0 = 1'b0; addr0 = 11'h155;
    req1 = 1'b1; we1 = 1'b0; addr1 = 11'h020;
    for (int i = 0; i < 5; i++) begin
      if (i == 4) begin req0 = 1'b0; req1 = 1'b0; end
      @(negedge clk);
      if (i < 4) check("tie_gnt", {gnt0, gnt1}, (i % 2 == 0) ? 2'b10 : 2'b01);
      if (i > 0) begin
        check("tie_vld", {vld0, vld1}, (i % 2 == 1) ? 2'b10 : 2'b01);
        check("tie_doa", doa, (i % 2 == 1) ? 2'b10 : 2'b01);
      end
      tick();
    end

    // Collision: R0 write vs port-B read at 0x7FF for 3 cycles
    req0 = 1'b1; we0 = 1'b1; addr0 = 11'h7FF; di0 = 2'b11;
    enb = 1'b1; web = 1'b0; addrb = 11'h7FF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("coll_stall", stall, 1);
      check("coll_gnt", {gnt0, gnt1, ena}, 0);
      tick();
    end
    enb = 1'b0;
    @(negedge clk);
    check("coll_late_gnt0", gnt0, 1);
    check("coll_late_stall", stall, 0);
    tick();
    we0 = 1'b0; enb = 1'b1; web = 1'b0; addrb = 11'h7FF;
    @(negedge clk);
    check("rdrd_gnt0", gnt0, 1);
    check("rdrd_stall", stall, 0);
    tick();
    req0 = 1'b0; enb = 1'b0;
    @(negedge clk);
    check("rdrd_vld0", vld0, 1);
    check("rdrd_doa", doa, 2'b11);
    tick();

    // Randomized traffic against a request-level model
    for (int i = 0; i < 2048; i++) sh[i] = mem[i];
    last_m = 0;
    pend[0] = 0; pend[1] = 0; expv[0] = 0; expv[1] = 0;
    expd[0] = 0; expd[1] = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int n = 0; n < 2; n++) begin
        if (!pend[n] && $urandom_range(2) != 0) begin
          pend[n] = 1;
          pwe[n]  = 1'($urandom_range(1));
          padr[n] = 11'h100 + 11'($urandom_range(7));
          pdi[n]  = 2'($urandom_range(3));
        end
      end
      req0 = pend[0]; we0 = pwe[0]; addr0 = padr[0]; di0 = pdi[0];
      req1 = pend[1]; we1 = pwe[1]; addr1 = padr[1]; di1 = pdi[1];
      enb   = ($urandom_range(3) == 0);
      web   = 1'($urandom_range(1));
      addrb = 11'h100 + 11'($urandom_range(7));

      if (pend[0] && pend[1]) c = (last_m == 1) ? 0 : 1;
      else if (pend[0])       c = 0;
      else if (pend[1])       c = 1;
      else                    c = -1;
      coll = (c >= 0) && enb && (addrb == padr[c]) && (web || pwe[c]);
      g    = (c >= 0) && !coll;

      @(negedge clk);
      check("rnd_gnt", {gnt0, gnt1}, {g && c == 0, g && c == 1});
      check("rnd_stall", stall, coll);
      check("rnd_ena", ena, g);
      if (g) begin
        check("rnd_wea", wea, pwe[c]);
        check("rnd_addra", addra, padr[c]);
        if (pwe[c]) check("rnd_dia", dia, pdi[c]);
      end
      check("rnd_vld", {vld0, vld1}, {expv[0], expv[1]});
      for (int n = 0; n < 2; n++) if (expv[n]) check("rnd_doa", doa, expd[n]);

      nv[0] = 0; nv[1] = 0; nd[0] = 0; nd[1] = 0;
      if (g) begin
        last_m = c;
        pend[c] = 0;
        if (pwe[c]) sh[padr[c]] = pdi[c];
        else begin nv[c] = 1; nd[c] = sh[padr[c]]; end
      end
      expv = nv;
      expd = nd;
      tick();
    end
    req0 = 1'b0; req1 = 1'b0; enb = 1'b0;
    tick();

    // Reset right after a read grant, then clear with a 2-cycle stall at CNT=5
    req1 = 1'b1; we1 = 1'b0; addr1 = 11'h155;
    @(negedge clk);
    check("mid_gnt1", gnt1, 1);
    tick();
    req1 = 1'b0; rst = 1'b1;
    @(negedge clk);
    check("mid_vld1", vld1, 0);
    check("mid_ready", ready, 0);
    check("mid_ena", ena, 0);
    tick();
    tick();
    rst = 1'b0;
    run_clear(5, 2, rc, wr, bad);
    check("stall_ready_cycle", rc, 2051);
    check("stall_writes", wr, 2048);
    check("stall_bad_writes", bad, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
